// File: rtl/jk_excite_driver_pkg.sv
// Shared types and helpers for the JK excitation driver.
// Optional feature macro: JK_TOGGLE_EN (toggle encoding for bits that must change).
package jk_excite_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    APPLY = 2'b01,
    CHECK = 2'b10
  } state_t;

  // Returns {J, K} needed to move a JK flop from q to t in one clock.
  function automatic logic [1:0] excite(input logic q, input logic t);
`ifdef JK_TOGGLE_EN
    excite = {q ^ t, q ^ t};
`else
    excite = {~q & t, q & ~t};
`endif
  endfunction

  function automatic int unsigned retry_width(input int unsigned max_retry);
    int unsigned w;
    w = $clog2(max_retry + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// Per-bit combinational (q, t) -> (J, K) encoder.
// Encoding selected by JK_TOGGLE_EN (set/reset when undefined, toggle when defined).
module jk_excite_cell
  import jk_excite_driver_pkg::*;
(
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);

  always_comb begin
    {j, k} = excite(q, t);
  end

endmodule

// File: rtl/jk_excite_driver.sv
// Drives a bank of JK flops to a target word: apply one cycle, check, retry, report.
// Honours JK_TOGGLE_EN via jk_excite_cell.
module jk_excite_driver
  import jk_excite_driver_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk1,
  input  logic             s_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned RW = retry_width(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             done_q, done_d, err_q, err_d;

  logic [WIDTH-1:0] exc_t, exc_j, exc_k;

  // In IDLE the excitation must track the live target so it can be loaded on accept.
  always_comb begin
    exc_t = (state_q == IDLE) ? target : target_q;
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_cell
    jk_excite_cell u_cell (
      .q (q_fb[b]),
      .t (exc_t[b]),
      .j (exc_j[b]),
      .k (exc_k[b])
    );
  end

  always_ff @(posedge clk1 or posedge s_reset) begin
    if (s_reset) begin
      state_q  <= IDLE;
      j_q      <= '0;
      k_q      <= '0;
      target_q <= '0;
      retry_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = '0;
    k_d      = '0;
    target_d = target_q;
    retry_d  = retry_q;
    done_d   = 1'b0;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d = target;
          err_d    = 1'b0;
          retry_d  = '0;
          j_d      = exc_j;
          k_d      = exc_k;
          state_d  = APPLY;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + RW'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = APPLY;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    j    = j_q;
    k    = k_q;
    busy = (state_q != IDLE);
    done = done_q;
    err  = err_q;
  end

endmodule

// File: doc/jk_excite_driver.md
# jk_excite_driver

Sequential driver that brings a bank of WIDTH JK flip-flops (instances of the team's JK_Sync cell) to a requested target word. It computes per-bit J/K excitation from the target and the bank's fed-back Q, applies it for one cycle, then checks the result. It retries on mismatch and reports done or error. It sits upstream of the JK register bank and is the producer side of the J/K interface that the JK cell consumes.

## Interface
- WIDTH, 4: number of JK flops driven; must be ≥ 1
- MAX_RETRY, 2: re-apply attempts after the first mismatch; must be ≥ 0
- clk1  in  1  clock; all state changes on rising edge
- s_reset  in  1  reset, asynchronous, active-high
- start  in  1  request pulse; sampled only in IDLE
- target  in  WIDTH  requested Q word; latched when start is accepted
- q_fb  in  WIDTH  current Q of the JK bank
- j  out  WIDTH  J inputs to the bank, registered
- k  out  WIDTH  K inputs to the bank, registered
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse on successful match
- err  out  1  sticky failure flag; cleared on the next accepted start

## Operation
- Reset: state=IDLE; j=0, k=0, busy=0, done=0, err=0, retry count=0, target_r=0.
- States:
  - IDLE. start=1 → latch target_r, clear err and retry count, load j/k from excitation(target, q_fb), go to APPLY.
  - APPLY. j/k are held for exactly one cycle. At the next edge: j,k←0 (hold), go to CHECK.
  - CHECK. q_fb==target_r → done=1 for one cycle, go to IDLE. Mismatch and retry<MAX_RETRY → retry+1, reload j/k from excitation(target_r, q_fb), go to APPLY. Mismatch and retry==MAX_RETRY → err=1, go to IDLE.
- Excitation, per bit, default encoding:
  - q=0, t=1 → J=1, K=0
  - q=1, t=0 → J=0, K=1
  - q==t → J=0, K=0
- j and k are 0 in every state except APPLY.
- start while busy: ignored, not queued.
- start with target==q_fb: j=k=0 in APPLY; done still pulses after CHECK.
- Reset asserted mid-operation: outputs go to reset values immediately (async). Any in-flight request is dropped with no done and no err.
- The retry counter is ceil(log2(MAX_RETRY+1)) bits, minimum 1. It never wraps.

## Timing
- start sampled at edge n → APPLY during cycle n..n+1 → bank updates at edge n+1 → CHECK during n+1..n+2 → compare at edge n+2.
- Success with no retry: done high during cycle n+2..n+3. busy high for exactly 2 cycles.
- Each retry adds 2 cycles. Worst case, err is set at edge n+2·(MAX_RETRY+1).
- done and err are never high in the same cycle.
- A new start is accepted in the same cycle done is high, because state is already IDLE.

## Configuration
- JK_TOGGLE_EN defined: bits that need to change are driven J=1, K=1 (toggle). Bits that hold stay J=0, K=0.
- JK_TOGGLE_EN undefined: set/reset encoding as in Operation.
- A correct bank gives the same final Q and identical cycle timing under both settings.

## Structure
- Shared package holds:
  - state encoding (IDLE=2'b00, APPLY=2'b01, CHECK=2'b10)
  - excitation function
  - retry-counter width function
- Sub-module jk_excite_cell: combinational per-bit (q, t) → (J, K) encoder, honouring JK_TOGGLE_EN. It is instantiated WIDTH times in a generate loop.

## Test plan
All scenarios use WIDTH=4, MAX_RETRY=2, with a behavioural JK bank on q_fb unless stated.
- Reset asserted: j=0000, k=0000, busy=0, done=0, err=0. Release → still IDLE.
- q_fb=0000, start with target=1010:
  - APPLY: j=1010, k=0000 (with JK_TOGGLE_EN: k=1010)
  - q_fb becomes 1010; done pulses at n+2; busy high for 2 cycles.
- q_fb=1010, target=0110: APPLY j=0100, k=1000 (toggle build: j=k=1100); done at n+2.
- q_fb forced to 0000, target=0001:
  - three APPLY phases, at n, n+2 and n+4
  - err=1 from edge n+6; done never asserted
  - next start clears err.
- Start again during busy: ignored. start with target==q_fb=0101: j=k=0000, done at n+2.
- s_reset pulsed during CHECK: j, k, busy, done and err drop to 0 asynchronously; no done follows.
